pipe_fetch_ctrl: RTL and testbench
==================================

PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of both performance counters.
REQ-003 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port stall  input  1  ID stage cannot accept an instruction this cycle (load-use or other hazard).
REQ-006 The block SHALL have port npc  input  32  next PC, already selected by the IF mux from pc4/branch/jr/jump.
REQ-007 The block SHALL have port imem_ready  input  1  instruction memory returns ins_in this cycle.
REQ-008 The block SHALL have port ins_in  input  32  instruction word from instruction memory.
REQ-009 The block SHALL have port pc  output  32  current fetch address, registered.
REQ-010 The block SHALL have port imem_req  output  1  fetch request to instruction memory at address pc.
REQ-011 The block SHALL have port ir_valid  output  1  one-cycle pulse: ir_ins/ir_pc4 carry a newly delivered instruction.
REQ-012 The block SHALL have port ir_ins  output  32  delivered instruction, registered.
REQ-013 The block SHALL have port ir_pc4  output  32  pc+4 of the delivered instruction, registered.
REQ-014 The block SHALL have ports fetch_cnt and stall_cnt  output  CNT_W each  delivered-instruction count and stalled-cycle count.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD.
REQ-016 IDLE SHALL last exactly one cycle after reset deassertion, with imem_req=0, then go to FETCH.
REQ-017 In FETCH imem_req SHALL be 1; imem_ready SHALL be ignored in every state other than FETCH.
REQ-018 FETCH with imem_ready=0 SHALL stay in FETCH with pc unchanged (any number of wait cycles).
REQ-019 FETCH with imem_ready=1 and stall=0 SHALL, at the edge: ir_ins<=ins_in, ir_pc4<=pc+4, ir_valid<=1, pc<=npc, stay in FETCH (one instruction per cycle with zero-wait memory).
REQ-020 FETCH with imem_ready=1 and stall=1 SHALL capture ins_in and pc+4 into a one-entry hold buffer, keep pc, keep ir_ins/ir_pc4, ir_valid<=0, go to HOLD.
REQ-021 In HOLD imem_req SHALL be 0; with stall=1 it SHALL stay in HOLD unchanged.
REQ-022 In HOLD with stall=0 it SHALL deliver the buffer (ir_ins, ir_pc4, ir_valid<=1), pc<=npc, go to FETCH.
REQ-023 ir_valid SHALL be 0 in every cycle not covered by REQ-019/REQ-022; ir_ins/ir_pc4 SHALL hold their last values.
REQ-024 pc SHALL change only on a delivery edge; pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-025 fetch_cnt SHALL increment on each ir_valid assertion; stall_cnt SHALL increment each cycle in HOLD; both SHALL wrap to 0 from all-ones.
REQ-026 stall asserted in FETCH while imem_ready=0 SHALL have no effect and SHALL NOT count.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, pc=RESET_PC, imem_req=0, ir_valid=0, ir_ins=0, ir_pc4=0, buffer empty, both counters 0.
REQ-028 Reset mid-wait or in HOLD SHALL discard the pending/buffered instruction without delivering it.

Structure
REQ-029 State encoding and the RESET_PC default SHALL live in shared package pipe_pkg.
REQ-030 The two counters SHALL be instances of one sub-module perf_counter (enable, wrap, async clear).

Verification
REQ-031 Reset release, imem_ready=1 always, stall=0, npc=pc+4 -> cycle 1 IDLE, then ir_valid every cycle, ir_pc4=4,8,12, fetch_cnt=3 after 3 deliveries.
REQ-032 imem_ready low 3 FETCH cycles then high, ins_in=32'h2001_0005 -> pc held at 0 for 3 cycles, single ir_valid with ir_ins=32'h2001_0005.
REQ-033 stall=1 for 2 cycles coincident with imem_ready=1 at pc=8 -> HOLD 2 cycles, imem_req=0, stall_cnt=2, then delivery with ir_pc4=12, pc<=npc.
REQ-034 npc=32'h0000_0040 (jump) at a delivery edge -> next pc=32'h40, next ir_pc4=32'h44.
REQ-035 Reset pulsed while in HOLD -> no ir_valid, pc=RESET_PC, counters 0, one IDLE cycle then FETCH.
REQ-036 pc=32'hFFFF_FFFC delivered -> ir_pc4=0; counter preset to all-ones then one delivery -> fetch_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the instruction-fetch controller: the FSM state
// encoding, the default reset PC, the default counter width and the
// sequential-PC helper.
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one cycle after reset release, no fetch request
    ST_FETCH = 2'd1,  // request outstanding at address pc
    ST_HOLD  = 2'd2   // instruction parked in the hold buffer while ID stalls
  } fetch_state_e;

  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;
  localparam int unsigned PIPE_CNT_W    = 32;

  // Address of the following sequential instruction; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] i_pc);
    return i_pc + 32'd4;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running event counter: increments by one on each enabled clock edge,
// wraps from all-ones to zero, asynchronously cleared.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high clear
//   i_en     count this cycle
//   o_count  current count (W bits)
// -----------------------------------------------------------------------------
module perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_fetch_ctrl
// IF-stage fetch controller. Issues fetch requests at pc, delivers returned
// instructions into the IF/ID register, and parks one instruction in a hold
// buffer when ID stalls on the same cycle memory returns data.
//
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous active-high reset
//   stall       ID cannot accept an instruction this cycle
//   npc         next PC chosen by the IF mux
//   imem_ready  instruction memory returns ins_in this cycle
//   ins_in      instruction word from memory
//   pc          current fetch address (registered)
//   imem_req    fetch request at pc
//   ir_valid    one-cycle pulse: ir_ins/ir_pc4 carry a new instruction
//   ir_ins      delivered instruction (registered)
//   ir_pc4      pc+4 of the delivered instruction (registered)
//   fetch_cnt   delivered-instruction count
//   stall_cnt   cycles spent in HOLD
// -----------------------------------------------------------------------------
module pipe_fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PIPE_RESET_PC,
  parameter int unsigned CNT_W    = PIPE_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      npc,
  input  logic             imem_ready,
  input  logic [31:0]      ins_in,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             ir_valid,
  output logic [31:0]      ir_ins,
  output logic [31:0]      ir_pc4,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [31:0] r_pc;
  logic        r_ir_valid;
  logic [31:0] r_ir_ins;
  logic [31:0] r_ir_pc4;
  logic [31:0] r_hold_ins;
  logic [31:0] r_hold_pc4;

  logic        w_deliver_fetch;
  logic        w_deliver_hold;
  logic        w_to_hold;
  logic        w_deliver;
  logic [31:0] w_pc4;

  assign w_pc4     = pc_plus4(r_pc);
  assign w_deliver = w_deliver_fetch | w_deliver_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_deliver_fetch = 1'b0;
    w_deliver_hold  = 1'b0;
    w_to_hold       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // stall only matters once memory has actually returned a word
        if (imem_ready) begin
          if (stall) begin
            w_to_hold    = 1'b1;
            w_next_state = ST_HOLD;
          end else begin
            w_deliver_fetch = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_deliver_hold = 1'b1;
          w_next_state   = ST_FETCH;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_ir_valid <= 1'b0;
      r_ir_ins   <= '0;
      r_ir_pc4   <= '0;
      r_hold_ins <= '0;
      r_hold_pc4 <= '0;
    end else begin
      r_ir_valid <= w_deliver;
      if (w_deliver_fetch) begin
        r_ir_ins <= ins_in;
        r_ir_pc4 <= w_pc4;
      end else if (w_deliver_hold) begin
        r_ir_ins <= r_hold_ins;
        r_ir_pc4 <= r_hold_pc4;
      end
      if (w_deliver) begin
        r_pc <= npc;
      end
      if (w_to_hold) begin
        r_hold_ins <= ins_in;
        r_hold_pc4 <= w_pc4;
      end
    end
  end

  perf_counter #(.W(CNT_W)) u_fetch_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_en    (w_deliver),
    .o_count (fetch_cnt)
  );

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_en    (r_state == ST_HOLD),
    .o_count (stall_cnt)
  );

  assign pc       = r_pc;
  assign imem_req = (r_state == ST_FETCH);
  assign ir_valid = r_ir_valid;
  assign ir_ins   = r_ir_ins;
  assign ir_pc4   = r_ir_pc4;

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_ctrl
// Self-checking bench for pipe_fetch_ctrl. A main instance runs a per-cycle
// vector table (sequential fetch, wait states, stall/hold, jump) with a
// scoreboard of accepted instruction words; a hand sequence covers reset in
// HOLD. A second instance with RESET_PC=32'hFFFF_FFFC and 2-bit counters
// covers pc+4 wrap and counter wrap.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_ctrl;

  logic        clk;
  logic        reset, stall, imem_ready;
  logic [31:0] npc, ins_in;
  logic [31:0] pc, ir_ins, ir_pc4;
  logic        imem_req, ir_valid;
  logic [31:0] fetch_cnt, stall_cnt;

  logic        rst2, stall2, ready2;
  logic [31:0] npc2, ins2;
  logic [31:0] pc2, ir_ins2, ir_pc42;
  logic        req2, valid2;
  logic [1:0]  fcnt2, scnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pipe_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .clock(clk), .reset(reset), .stall(stall), .npc(npc),
    .imem_ready(imem_ready), .ins_in(ins_in), .pc(pc), .imem_req(imem_req),
    .ir_valid(ir_valid), .ir_ins(ir_ins), .ir_pc4(ir_pc4),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  pipe_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
    .clock(clk), .reset(rst2), .stall(stall2), .npc(npc2),
    .imem_ready(ready2), .ins_in(ins2), .pc(pc2), .imem_req(req2),
    .ir_valid(valid2), .ir_ins(ir_ins2), .ir_pc4(ir_pc42),
    .fetch_cnt(fcnt2), .stall_cnt(scnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ready;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        exp_req;    // imem_req during the cycle
    logic [31:0] exp_pc;     // pc during the cycle
    logic        exp_valid;  // ir_valid after the edge
    int unsigned exp_fcnt;   // fetch_cnt after the edge
    int unsigned exp_scnt;   // stall_cnt after the edge
  } vec_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
  } sb_t;

  vec_t vecs[12];
  sb_t  sb[$];
  sb_t  last;
  sb_t  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    //           stall ready ins           npc           req pc            vld f  s
    vecs[0]  = '{1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b0, 0, 0}; // IDLE ignores ready
    vecs[1]  = '{1'b0, 1'b1, 32'h1000_0001, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1, 1, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1000_0002, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b1, 2, 0};
    vecs[3]  = '{1'b1, 1'b1, 32'h3000_0008, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0, 2, 0}; // into HOLD
    vecs[4]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b0, 2, 1}; // HOLD, ready ignored
    vecs[5]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b1, 3, 2}; // buffer delivered
    vecs[6]  = '{1'b0, 1'b0, 32'hBAD0_0001, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 3, 2}; // wait
    vecs[7]  = '{1'b1, 1'b0, 32'hBAD0_0002, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 3, 2}; // stall while waiting
    vecs[8]  = '{1'b0, 1'b0, 32'hBAD0_0003, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 3, 2}; // wait
    vecs[9]  = '{1'b0, 1'b1, 32'h2001_0005, 32'h0000_0040, 1'b1, 32'h0000_000C, 1'b1, 4, 2}; // jump
    vecs[10] = '{1'b0, 1'b1, 32'h4000_0040, 32'h0000_0044, 1'b1, 32'h0000_0040, 1'b1, 5, 2};
    vecs[11] = '{1'b1, 1'b1, 32'h5000_0044, 32'h0000_0048, 1'b1, 32'h0000_0044, 1'b0, 5, 2}; // into HOLD

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; npc = '0; ins_in = '0;
    rst2 = 1'b1; stall2 = 1'b0; ready2 = 1'b0; npc2 = '0; ins2 = '0;
    last = '{32'h0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_ir_ins", ir_ins, 32'h0);
    chk("rst_ir_pc4", ir_pc4, 32'h0);
    chk("rst_fcnt", fetch_cnt, 32'h0);
    chk("rst_scnt", stall_cnt, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].stall; imem_ready = vecs[i].ready;
      ins_in = vecs[i].ins; npc = vecs[i].npc;
      #1;
      chk("pc", pc, vecs[i].exp_pc);
      chk("imem_req", {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].ready && vecs[i].exp_req)
        sb.push_back('{vecs[i].ins, vecs[i].exp_pc + 32'd4});
      @(posedge clk);
      #1;
      chk("ir_valid", {31'b0, ir_valid}, {31'b0, vecs[i].exp_valid});
      if (ir_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sb_empty: got ir_valid with ir_ins %h, required no delivery", ir_ins);
        end else begin
          e = sb.pop_front();
          chk("ir_ins", ir_ins, e.ins);
          chk("ir_pc4", ir_pc4, e.pc4);
          last = e;
        end
      end else begin
        chk("ir_ins_hold", ir_ins, last.ins);
        chk("ir_pc4_hold", ir_pc4, last.pc4);
      end
      chk("fetch_cnt", fetch_cnt, vecs[i].exp_fcnt);
      chk("stall_cnt", stall_cnt, vecs[i].exp_scnt);
      @(negedge clk);
    end

    // Reset arrives mid-cycle while an instruction is parked in HOLD.
    stall = 1'b1; imem_ready = 1'b0;
    #1;
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'b0, imem_req}, 32'h0);
    chk("async_valid", {31'b0, ir_valid}, 32'h0);
    chk("async_ir_ins", ir_ins, 32'h0);
    chk("async_fcnt", fetch_cnt, 32'h0);
    chk("async_scnt", stall_cnt, 32'h0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; ins_in = 32'h7777_7777; npc = 32'h4;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    chk("idle_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'b0, ir_valid}, 32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_valid2", {31'b0, ir_valid}, 32'h0);
    chk("post_rst_ir_ins", ir_ins, 32'h0);
    chk("post_rst_fcnt", fetch_cnt, 32'h0);
    chk("post_rst_scnt", stall_cnt, 32'h0);

    // pc+4 wrap from 32'hFFFF_FFFC and 2-bit fetch counter wrap.
    @(negedge clk);
    rst2 = 1'b0; ready2 = 1'b1; stall2 = 1'b0; ins2 = 32'h0BAD_0000; npc2 = 32'h0;
    #1;
    chk("wrap_idle_req", {31'b0, req2}, 32'h0);
    chk("wrap_idle_pc", pc2, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap_idle_valid", {31'b0, valid2}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ins2 = 32'hA000_0000 + 32'(k);
      npc2 = 32'(k) * 32'd4;
      #1;
      chk("wrap_pc", pc2, (k == 0) ? 32'hFFFF_FFFC : 32'(k - 1) * 32'd4);
      @(posedge clk);
      #1;
      chk("wrap_valid", {31'b0, valid2}, 32'h1);
      chk("wrap_ir_ins", ir_ins2, 32'hA000_0000 + 32'(k));
      chk("wrap_ir_pc4", ir_pc42, 32'(k) * 32'd4);
      chk("wrap_fcnt", {30'b0, fcnt2}, 32'((k + 1) % 4));
    end

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL sb_leftover: got %0d pending entries, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
